instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 14 +
 rtl/instr_fetch_unit_prog_mem.sv | 26 ++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
// The T0/T3 phase constants are also used by the program counter.
package instr_fetch_unit_pkg;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int INSTR_W = 8;
  localparam int CNT_W   = ADDR_W + 1;

  localparam logic [3:0]         HLT_OPC   = 4'hF;
  localparam logic [INSTR_W-1:0] NOP       = 8'h00;
  localparam logic [1:0]         T0        = 2'b00;
  localparam logic [1:0]         T3        = 2'b11;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-load byte stream: the loader is the master, the fetch unit the slave.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               prog_en;
  logic               prog_valid;
  logic [INSTR_W-1:0] prog_data;
  logic               prog_ready;
  logic               prog_done;

  modport master (output prog_en, prog_valid, prog_data, input prog_ready, prog_done);
  modport slave  (input prog_en, prog_valid, prog_data, output prog_ready, prog_done);

endinterface

// File: rtl/instr_fetch_unit_prog_mem.sv
// 32 x 8 program store: async clear to NOP, one sync write port, one comb read port.
module prog_mem
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program store plus instruction register: loads the program, fetches at T0,
// and parks in HALT on an HLT opcode or after executing the word at address 31.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               timing_signal,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     run_en,
  instr_fetch_unit_if.slave        prog,
  output logic [3:0]               ir_opcode,
  output logic [3:0]               ir_operand,
  output logic                     ir_valid,
  output logic                     halted
);

  state_t             state, next_state;
  logic [INSTR_W-1:0] ir, next_ir;
  logic               next_ir_valid, next_halted;
  logic               done, next_done;
  logic               last_flag, next_last;
  logic [CNT_W-1:0]   wr_cnt, next_cnt;
  logic               ready, accept, load_full;
  logic [INSTR_W-1:0] fetch_word;

  prog_mem u_prog_mem (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (wr_cnt[ADDR_W-1:0]),
    .wdata (prog.prog_data),
    .raddr (pc_in),
    .rdata (fetch_word)
  );

  assign load_full       = (wr_cnt == CNT_W'(DEPTH));
  assign ready           = (state == LOAD) && !load_full;
  assign accept          = prog.prog_valid && ready;
  assign prog.prog_ready = ready;
  assign prog.prog_done  = done;
  assign ir_opcode       = ir[INSTR_W-1 -: 4];
  assign ir_operand      = ir[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ir        <= NOP;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      done      <= 1'b0;
      last_flag <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      state     <= next_state;
      ir        <= next_ir;
      ir_valid  <= next_ir_valid;
      halted    <= next_halted;
      done      <= next_done;
      last_flag <= next_last;
      wr_cnt    <= next_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_ir       = ir;
    next_ir_valid = ir_valid;
    next_halted   = halted;
    next_done     = 1'b0;
    next_last     = last_flag;
    next_cnt      = wr_cnt;
    case (state)
      IDLE: begin
        if (prog.prog_en) begin
          next_state = LOAD;
          next_cnt   = '0;
        end else if (run_en) begin
          next_state = RUN;
        end
      end
      LOAD: begin
        if (accept) next_cnt = wr_cnt + CNT_W'(1);
        // A byte accepted on the same edge prog_en falls is still written above.
        if (!prog.prog_en || load_full) begin
          next_state = IDLE;
          next_done  = 1'b1;
        end
      end
      RUN: begin
        if (timing_signal == T0) begin
          next_ir = fetch_word;
          if (fetch_word[INSTR_W-1 -: 4] == HLT_OPC) begin
            next_state    = HALT;
            next_ir_valid = 1'b0;
            next_halted   = 1'b1;
          end else begin
            next_ir_valid = 1'b1;
            if (pc_in == LAST_ADDR) next_last = 1'b1;
          end
        end else if (timing_signal == T3 && last_flag) begin
          // The last word has finished its T1..T3 execution window.
          next_state    = HALT;
          next_ir_valid = 1'b0;
          next_halted   = 1'b1;
        end
      end
      HALT: begin
        if (prog.prog_en) begin
          next_state  = LOAD;
          next_halted = 1'b0;
          next_last   = 1'b0;
          next_cnt    = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: drives load streams and a PC/phase sequence, comparing
// the unit against a word-array model of program memory and halt rules.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [1:0] timing_signal;
  logic [4:0] pc_in;
  logic       run_en;
  logic [3:0] ir_opcode, ir_operand;
  logic       ir_valid, halted;

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .timing_signal (timing_signal),
    .pc_in         (pc_in),
    .run_en        (run_en),
    .prog          (bus),
    .ir_opcode     (ir_opcode),
    .ir_operand    (ir_operand),
    .ir_valid      (ir_valid),
    .halted        (halted)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [0:31];
  logic [7:0] stim [0:39];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
  endtask

  // Start at phase entry_phase, then step PC 0,1,2.. per T0..T3 round until the model says HALT.
  task automatic run_program(input int entry_phase);
    int pc;
    bit done;
    bit exp_halt;
    logic [7:0] w;
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    run_en = 1'b1;
    timing_signal = 2'(entry_phase);
    tick();
    run_en = 1'b0;
    for (int ph = entry_phase + 1; ph < 4; ph++) begin
      timing_signal = 2'(ph);
      tick();
      checks++;
      if (ir_valid !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pre_fetch ph=%0d got valid=%b halted=%b exp valid=0 halted=0", ph, ir_valid, halted);
      end
    end
    pc = 0;
    done = 0;
    w = 8'h00;
    while (!done) begin
      w = model_mem[pc];
      for (int ph = 0; ph < 4 && !done; ph++) begin
        timing_signal = 2'(ph);
        pc_in = (ph == 0) ? 5'(pc) : 5'($urandom);
        bus.prog_en = (ph == 1 || ph == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.prog_valid = 1'($urandom_range(0, 1));
        bus.prog_data = 8'($urandom);
        run_en = 1'($urandom_range(0, 1));
        tick();
        exp_halt = (w[7:4] == 4'hF) || (pc == 31 && ph == 3);
        checks++;
        if ({ir_opcode, ir_operand} !== w || ir_valid !== !exp_halt || halted !== exp_halt) begin
          errors++;
          $display("[TB] FAIL fetch pc=%0d ph=%0d got ir=%h valid=%b halted=%b exp ir=%h valid=%b halted=%b",
                   pc, ph, {ir_opcode, ir_operand}, ir_valid, halted, w, !exp_halt, exp_halt);
        end
        if (exp_halt) done = 1;
      end
      pc++;
    end
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      timing_signal = 2'b00;
      pc_in = 5'($urandom);
      run_en = 1'b1;
      tick();
      checks++;
      if ({ir_opcode, ir_operand} !== w || ir_valid !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("[TB] FAIL halt_hold got ir=%h valid=%b halted=%b exp ir=%h valid=0 halted=1",
                 {ir_opcode, ir_operand}, ir_valid, halted, w);
      end
    end
    run_en = 1'b0;
  endtask

  // Stream stim[0..n-1]; optionally drop prog_en together with the last byte.
  task automatic load_stream(input int n, input bit drop_with_last);
    int cnt;
    int done_seen;
    bit in_load;
    bit leave;
    run_en = 1'b0;
    bus.prog_en = 1'b1;
    bus.prog_valid = 1'b0;
    tick();
    checks++;
    if (halted !== 1'b0 || bus.prog_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_entry got halted=%b ready=%b exp halted=0 ready=1", halted, bus.prog_ready);
    end
    cnt = 0;
    done_seen = 0;
    in_load = 1;
    for (int i = 0; i < n && in_load; i++) begin
      checks++;
      if (bus.prog_ready !== (cnt < 32)) begin
        errors++;
        $display("[TB] FAIL prog_ready byte=%0d got %b exp %b", i, bus.prog_ready, (cnt < 32));
      end
      bus.prog_valid = 1'b1;
      bus.prog_data = stim[i];
      if (drop_with_last && i == n - 1) bus.prog_en = 1'b0;
      leave = !bus.prog_en || cnt == 32;
      if (cnt < 32) begin
        model_mem[cnt] = stim[i];
        cnt++;
      end
      tick();
      done_seen += int'(bus.prog_done);
      if (leave) in_load = 0;
    end
    bus.prog_valid = 1'b0;
    bus.prog_en = 1'b0;
    if (in_load) begin
      tick();
      done_seen += int'(bus.prog_done);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      done_seen += int'(bus.prog_done);
    end
    checks++;
    if (done_seen != 1 || bus.prog_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prog_done got pulses=%0d ready=%b exp pulses=1 ready=0", done_seen, bus.prog_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h exp 000",
               {ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done});
    end
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run_program(3);
  endtask

  task automatic test_short_program();
    stim[0] = 8'h12;
    stim[1] = 8'h34;
    stim[2] = 8'hF0;
    load_stream(3, 1'b0);
    run_program(3);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 32; i++) stim[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
    stim[32] = ~stim[0];
    load_stream(33, 1'b0);
    run_program(3);
  endtask

  task automatic test_last_byte_drop();
    for (int i = 0; i < 5; i++) stim[i] = 8'($urandom);
    load_stream(5, 1'b1);
    run_program(3);
  endtask

  task automatic test_mid_phase_entry();
    for (int i = 0; i < 4; i++) stim[i] = {4'($urandom_range(1, 14)), 4'($urandom)};
    load_stream(4, 1'b0);
    run_program(2);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    bus.prog_en = 1'b1;
    bus.prog_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data = stim[i];
      tick();
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid_load got %h exp 000",
               {ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done});
    end
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run_program(3);
  endtask

  task automatic test_reset_mid_run();
    stim[0] = {4'($urandom_range(1, 14)), 4'($urandom)};
    for (int i = 1; i < 4; i++) stim[i] = 8'($urandom);
    load_stream(4, 1'b0);
    run_en = 1'b1;
    timing_signal = 2'b11;
    tick();
    run_en = 1'b0;
    timing_signal = 2'b00;
    pc_in = 5'd0;
    tick();
    timing_signal = 2'b01;
    bus.prog_en = 1'b1;
    bus.prog_valid = 1'b1;
    bus.prog_data = 8'($urandom);
    tick();
    checks++;
    if ({ir_opcode, ir_operand} !== stim[0] || ir_valid !== 1'b1 || bus.prog_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_ignores_load got ir=%h valid=%b ready=%b exp ir=%h valid=1 ready=0",
               {ir_opcode, ir_operand}, ir_valid, bus.prog_ready, stim[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got %h exp 000",
               {ir_opcode, ir_operand, ir_valid, halted, bus.prog_ready, bus.prog_done});
    end
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run_program(3);
  endtask

  initial begin
    reset = 1'b1;
    timing_signal = 2'b00;
    pc_in = 5'd0;
    run_en = 1'b0;
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_data = 8'h00;
    test_reset();
    test_short_program();
    test_full_load();
    test_last_byte_drop();
    test_mid_phase_entry();
    test_reset_mid_load();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
